// File: rtl/ctrl_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) and execute (T3-T6) strobes for the
// register datapath, decoded from the current state and the datapath IR.
module ctrl_sequencer #(
    parameter int NUM_REGS     = 16,
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic                pc_out,
    output logic                mar_enable,
    output logic                pc_increment,
    output logic                read,
    output logic                mdr_enable,
    output logic                mdr_out,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                z_enable,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                lo_enable,
    output logic                hi_enable,
    output logic [NUM_REGS-1:0] r_out,
    output logic [NUM_REGS-1:0] r_enable,
    output logic [4:0]          op_code,
    output logic                instr_done,
    output logic                illegal,
    output logic                bus_error
);

    localparam int CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    typedef enum logic [1:0] {
        C_ALU3, C_MULDIV, C_UNARY, C_BAD
    } iclass_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    iclass_t          iclass;
    logic             is_end;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       unused_ir_bits;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    // Indices beyond the implemented register file select nothing.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
        logic [NUM_REGS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) sel[i] = 1'b1;
        end
        return sel;
    endfunction

    always_comb begin
        if (opcode >= 5'd3 && opcode <= 5'd11)
            iclass = C_ALU3;
        else if (opcode == 5'd15 || opcode == 5'd16)
            iclass = C_MULDIV;
        else if (opcode == 5'd17 || opcode == 5'd18)
            iclass = C_UNARY;
        else
            iclass = C_BAD;
    end

    always_comb begin
        is_end = 1'b0;
        case (state)
            S_T4:    is_end = (iclass == C_UNARY);
            S_T5:    is_end = (iclass == C_ALU3);
            S_T6:    is_end = (iclass == C_MULDIV);
            default: is_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run && !illegal && !bus_error) state <= S_T0;
                end
                S_T0: begin
                    wait_cnt <= '0;
                    state    <= S_T1;
                end
                S_T1: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        state    <= S_T2;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt  <= '0;
                        bus_error <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    if (iclass == C_BAD) begin
                        illegal <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_T4;
                    end
                end
                S_T4, S_T5, S_T6: begin
                    // run is only consulted here, so an instruction always runs to completion.
                    if (is_end)
                        state <= run ? S_T0 : S_IDLE;
                    else if (state == S_T4)
                        state <= S_T5;
                    else if (state == S_T5)
                        state <= S_T6;
                    else
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_out       = 1'b0;
        mar_enable   = 1'b0;
        pc_increment = 1'b0;
        read         = 1'b0;
        mdr_enable   = 1'b0;
        mdr_out      = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        r_out        = '0;
        r_enable     = '0;
        op_code      = 5'd0;
        instr_done   = 1'b0;
        case (state)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
            end
            S_T1: begin
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: begin
                case (iclass)
                    C_ALU3: begin
                        r_out    = reg_sel(rb);
                        y_enable = 1'b1;
                    end
                    C_MULDIV: begin
                        r_out    = reg_sel(ra);
                        y_enable = 1'b1;
                    end
                    C_UNARY: begin
                        r_out    = reg_sel(rb);
                        z_enable = 1'b1;
                        op_code  = opcode;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (iclass)
                    C_ALU3: begin
                        r_out    = reg_sel(rc);
                        z_enable = 1'b1;
                        op_code  = opcode;
                    end
                    C_MULDIV: begin
                        r_out    = reg_sel(rb);
                        z_enable = 1'b1;
                        op_code  = opcode;
                    end
                    C_UNARY: begin
                        zlo_out    = 1'b1;
                        r_enable   = reg_sel(ra);
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (iclass)
                    C_ALU3: begin
                        zlo_out    = 1'b1;
                        r_enable   = reg_sel(ra);
                        instr_done = 1'b1;
                    end
                    C_MULDIV: begin
                        zlo_out   = 1'b1;
                        lo_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                if (iclass == C_MULDIV) begin
                    zhi_out    = 1'b1;
                    hi_enable  = 1'b1;
                    instr_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
